// File: rtl/fitbit_step_stats.sv
// Activity statistics: step totals, per-second rate, active/elapsed seconds
// and a rotating display selection, all derived from synchronized edges.
module fitbit_step_stats #(
    parameter int unsigned TOTAL_MAX   = 9999,
    parameter int unsigned RATE_THRESH = 2,
    parameter int unsigned DISP_SECS   = 2
) (
    input  logic        otherclk,
    input  logic        rst_n,
    input  logic        slowclk,
    input  logic        pulse,
    output logic [13:0] total_steps,
    output logic [7:0]  sec_steps,
    output logic [13:0] active_secs,
    output logic [13:0] elapsed_secs,
    output logic        over_flag,
    output logic [1:0]  disp_sel,
    output logic [13:0] disp_value
);

    localparam logic [13:0] TMAX  = 14'(TOTAL_MAX);
    localparam logic [7:0]  DLAST = 8'(DISP_SECS - 1);

    logic [1:0] s_sync;
    logic [1:0] p_sync;
    logic       s_edge;
    logic       p_edge;
    logic       tick;
    logic       step;
    logic [7:0] cur_cnt;
    logic [7:0] cur_eff;
    logic [7:0] disp_cnt;

    always_ff @(posedge otherclk or negedge rst_n) begin
        if (!rst_n) begin
            s_sync <= '0;
            p_sync <= '0;
            s_edge <= 1'b0;
            p_edge <= 1'b0;
        end else begin
            s_sync <= {s_sync[0], slowclk};
            p_sync <= {p_sync[0], pulse};
            s_edge <= s_sync[1];
            p_edge <= p_sync[1];
        end
    end

    assign tick = s_sync[1] & ~s_edge;
    assign step = p_sync[1] & ~p_edge;

    // A step coinciding with a tick belongs to the second being closed.
    assign cur_eff = (step && cur_cnt != 8'hFF) ? cur_cnt + 8'd1 : cur_cnt;

    always_ff @(posedge otherclk or negedge rst_n) begin
        if (!rst_n) begin
            total_steps <= '0;
        end else if (step && total_steps != TMAX) begin
            total_steps <= total_steps + 14'd1;
        end
    end

    always_ff @(posedge otherclk or negedge rst_n) begin
        if (!rst_n) begin
            cur_cnt      <= '0;
            sec_steps    <= '0;
            active_secs  <= '0;
            elapsed_secs <= '0;
        end else if (tick) begin
            cur_cnt   <= '0;
            sec_steps <= cur_eff;
            if (32'(cur_eff) >= RATE_THRESH && active_secs != TMAX) begin
                active_secs <= active_secs + 14'd1;
            end
            if (elapsed_secs != TMAX) begin
                elapsed_secs <= elapsed_secs + 14'd1;
            end
        end else begin
            cur_cnt <= cur_eff;
        end
    end

    always_ff @(posedge otherclk or negedge rst_n) begin
        if (!rst_n) begin
            disp_cnt <= '0;
            disp_sel <= '0;
        end else if (tick) begin
            if (disp_cnt == DLAST) begin
                disp_cnt <= '0;
                disp_sel <= disp_sel + 2'd1;
            end else begin
                disp_cnt <= disp_cnt + 8'd1;
            end
        end
    end

    assign over_flag = (total_steps == TMAX);

    always_comb begin
        disp_value = '0;
        unique case (disp_sel)
            2'd0: disp_value = total_steps;
            2'd1: disp_value = {6'd0, sec_steps};
            2'd2: disp_value = active_secs;
            2'd3: disp_value = elapsed_secs;
        endcase
    end

endmodule

// File: tb/tb_fitbit_step_stats.sv
// Bench for fitbit_step_stats: directed table, latency and corner sequences,
// and randomized events against an event-level statistics model.
module tb_fitbit_step_stats;

    logic        otherclk = 1'b0;
    logic        rst_n    = 1'b0;
    logic        slowclk  = 1'b0;
    logic        pulse    = 1'b0;
    logic [13:0] total_steps;
    logic [7:0]  sec_steps;
    logic [13:0] active_secs;
    logic [13:0] elapsed_secs;
    logic        over_flag;
    logic [1:0]  disp_sel;
    logic [13:0] disp_value;

    fitbit_step_stats dut (
        .otherclk     (otherclk),
        .rst_n        (rst_n),
        .slowclk      (slowclk),
        .pulse        (pulse),
        .total_steps  (total_steps),
        .sec_steps    (sec_steps),
        .active_secs  (active_secs),
        .elapsed_secs (elapsed_secs),
        .over_flag    (over_flag),
        .disp_sel     (disp_sel),
        .disp_value   (disp_value)
    );

    always #5 otherclk = ~otherclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Event-level model: raw counts since reset, saturation applied on read.
    int m_steps, m_cur, m_sec, m_active, m_elapsed, m_ticks;

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_steps = 0; m_cur = 0; m_sec = 0;
        m_active = 0; m_elapsed = 0; m_ticks = 0;
    endtask

    task automatic model_event(input bit p, input bit t);
        if (p) begin
            m_steps++;
            m_cur = sat(m_cur + 1, 255);
        end
        if (t) begin
            m_sec = m_cur;
            if (m_cur >= 2) m_active++;
            m_elapsed++;
            m_ticks++;
            m_cur = 0;
        end
    endtask

    task automatic check_all(input string tag);
        int sel;
        int val;
        sel = (m_ticks / 2) % 4;
        case (sel)
            0: val = sat(m_steps, 9999);
            1: val = m_sec;
            2: val = sat(m_active, 9999);
            default: val = sat(m_elapsed, 9999);
        endcase
        check({tag, ".total"}, int'(total_steps), sat(m_steps, 9999));
        check({tag, ".sec"}, int'(sec_steps), m_sec);
        check({tag, ".active"}, int'(active_secs), sat(m_active, 9999));
        check({tag, ".elapsed"}, int'(elapsed_secs), sat(m_elapsed, 9999));
        check({tag, ".over"}, int'(over_flag), int'(m_steps >= 9999));
        check({tag, ".sel"}, int'(disp_sel), sel);
        check({tag, ".value"}, int'(disp_value), val);
    endtask

    task automatic do_reset();
        @(negedge otherclk);
        rst_n = 1'b0; pulse = 1'b0; slowclk = 1'b0;
        repeat (3) @(negedge otherclk);
        rst_n = 1'b1;
        repeat (2) @(negedge otherclk);
        model_reset();
    endtask

    // One event: optional step and/or tick, rising on the same clock edge.
    task automatic ev(input bit p, input bit t);
        @(negedge otherclk);
        pulse = p; slowclk = t;
        repeat (3) @(negedge otherclk);
        pulse = 1'b0; slowclk = 1'b0;
        repeat (3) @(negedge otherclk);
        model_event(p, t);
    endtask

    task automatic fast_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge otherclk); pulse = 1'b1;
            repeat (2) @(negedge otherclk); pulse = 1'b0;
            @(negedge otherclk);
            model_event(1'b1, 1'b0);
        end
        repeat (4) @(negedge otherclk);
    endtask

    typedef struct {
        int npulse;
        bit both;
        int exp_sec;
        int exp_act_inc;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0;
        tbl[0] = '{3, 1'b0, 3, 1};
        tbl[1] = '{1, 1'b0, 1, 0};
        tbl[2] = '{1, 1'b1, 2, 1};
        tbl[3] = '{0, 1'b0, 0, 0};
        tbl[4] = '{2, 1'b0, 2, 1};
        tbl[5] = '{0, 1'b1, 1, 0};

        // Async reset state
        #2;
        check_all("reset");
        do_reset();
        check_all("post_reset");

        // Exact step latency: new value after the third sampling edge
        @(negedge otherclk); pulse = 1'b1;
        repeat (2) @(posedge otherclk);
        #1 check("lat.before", int'(total_steps), 0);
        @(posedge otherclk);
        #1 check("lat.after", int'(total_steps), 1);
        repeat (10) @(negedge otherclk);
        check("lat.single", int'(total_steps), 1);
        pulse = 1'b0;
        repeat (3) @(negedge otherclk);
        model_event(1'b1, 1'b0);

        // Exact tick latency
        @(negedge otherclk); slowclk = 1'b1;
        repeat (2) @(posedge otherclk);
        #1 check("tlat.before", int'(elapsed_secs), 0);
        @(posedge otherclk);
        #1 check("tlat.after", int'(elapsed_secs), 1);
        check("tlat.sec", int'(sec_steps), 1);
        @(negedge otherclk); slowclk = 1'b0;
        repeat (3) @(negedge otherclk);
        model_event(1'b0, 1'b1);

        // Input already high at reset release gives one strobe
        @(negedge otherclk); rst_n = 1'b0; pulse = 1'b1;
        repeat (2) @(negedge otherclk); rst_n = 1'b1;
        repeat (8) @(negedge otherclk); pulse = 1'b0;
        repeat (3) @(negedge otherclk);
        model_reset();
        model_event(1'b1, 1'b0);
        check_all("held_at_release");

        // Directed per-second table
        do_reset();
        for (int i = 0; i < 6; i++) begin
            a0 = m_active;
            for (int k = 0; k < tbl[i].npulse; k++) ev(1'b1, 1'b0);
            ev(tbl[i].both, 1'b1);
            check($sformatf("tbl%0d.sec", i), int'(sec_steps), tbl[i].exp_sec);
            check($sformatf("tbl%0d.act", i), int'(active_secs),
                  a0 + tbl[i].exp_act_inc);
            check_all($sformatf("tbl%0d", i));
        end

        // Display rotation over 8 ticks
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            if (k % 3 == 0) ev(1'b1, 1'b0);
            ev(1'b0, 1'b1);
            check_all($sformatf("disp%0d", k));
        end

        // Randomized events
        do_reset();
        for (int i = 0; i < 150; i++) begin
            bit p;
            bit t;
            p = ($urandom_range(0, 99) < 70);
            t = ($urandom_range(0, 99) < 30);
            ev(p, t);
            check_all($sformatf("rnd%0d", i));
        end

        // Saturation of total and per-second counts
        do_reset();
        fast_pulses(10000);
        check_all("sat_total");
        check("sat.over", int'(over_flag), 1);
        fast_pulses(300);
        ev(1'b0, 1'b1);
        check("sat.sec255", int'(sec_steps), 255);
        check_all("sat_sec");

        // Mid-second reset clears everything at once
        do_reset();
        fast_pulses(35);
        ev(1'b0, 1'b1);
        fast_pulses(5);
        check("mid.total40", int'(total_steps), 40);
        @(negedge otherclk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("mid_reset");
        @(negedge otherclk);
        rst_n = 1'b1;
        repeat (2) @(negedge otherclk);
        ev(1'b0, 1'b1);
        check("mid.sec0", int'(sec_steps), 0);
        check_all("mid_after");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fitbit_step_stats.md
Name: fitbit_step_stats

Overview:
- Activity-statistics stage directly downstream of the 1 Hz clock divider.
- Runs on the fast system clock and samples the divider's slowclk square wave as data; each rising edge marks a one-second tick.
- Counts step pulses from the step-pulse source and maintains total steps, steps per second, active seconds and elapsed seconds.
- Cycles a 4-way display selection for the seven-segment driver.

Parameters:
TOTAL_MAX, 9999, saturation ceiling for total_steps, active_secs and elapsed_secs.
RATE_THRESH, 2, minimum steps in one second for that second to count as active.
DISP_SECS, 2, number of second ticks each display mode is held.

Ports:
otherclk  input  1  fast system clock; every register is clocked on its rising edge.
rst_n  input  1  asynchronous active-low reset.
slowclk  input  1  1 Hz square wave from the divider; rising edge = second tick.
pulse  input  1  step pulse, asynchronous to otherclk; rising edge = one step.
total_steps  output  14  steps since reset, saturating at TOTAL_MAX.
sec_steps  output  8  step count of the most recently completed second, saturating at 255.
active_secs  output  14  completed seconds with step count >= RATE_THRESH, saturating.
elapsed_secs  output  14  second ticks since reset, saturating.
over_flag  output  1  high while total_steps == TOTAL_MAX.
disp_sel  output  2  current display mode, 0..3.
disp_value  output  14  value selected by disp_sel.

Behaviour:
- Reset (rst_n low, async): every register and output is 0. This includes the sync flops, edge flops, the per-second accumulator cur_cnt and the display tick counter.
- Input conditioning:
  - slowclk and pulse each pass through a 2-flop synchronizer, then an edge register.
  - tick = sync & ~edge_reg; step = same form on pulse. Each is a one-cycle strobe.
  - An input already high at reset release yields exactly one strobe.
- Latency: a rising input edge at cycle N sets its strobe at N+2; the affected outputs show the new value at N+3.
- On step:
  - total_steps increments unless already TOTAL_MAX; it then holds.
  - cur_cnt increments, saturating at 255.
- On tick:
  - sec_steps <= cur_cnt_eff, where cur_cnt_eff = cur_cnt + step, saturated at 255.
  - cur_cnt <= 0.
  - active_secs increments (saturating) if cur_cnt_eff >= RATE_THRESH.
  - elapsed_secs increments (saturating).
  - The display tick counter increments. When it would reach DISP_SECS, it clears to 0 and disp_sel advances mod 4 (3 wraps to 0).
- Simultaneous step and tick in the same cycle: the step belongs to the closing second. It is included in sec_steps and the active test, and the new cur_cnt is 0.
- over_flag = (total_steps == TOTAL_MAX), driven combinationally from the register.
- Display mux (combinational from registers):
  - 0: total_steps
  - 1: sec_steps zero-extended
  - 2: active_secs
  - 3: elapsed_secs
- Reset mid-operation clears all state immediately. There is no partial-second carry-over after reset release.
- Width rules: all saturation is compare-before-increment. No counter ever wraps to 0.

Test Plan:
- Reset then 3 pulses, each a 20-cycle-wide high: total_steps=3 and cur_cnt=3; on the next slowclk rise, sec_steps=3, active_secs=1 and elapsed_secs=1, all at edge+3 cycles.
- One pulse in a second, then a tick: sec_steps=1, active_secs unchanged (1 < RATE_THRESH=2), elapsed_secs increments.
- pulse and slowclk rising on the same otherclk edge, with cur_cnt=1 beforehand: sec_steps=2, active_secs increments, cur_cnt=0, total_steps increments by 1.
- Preload by driving 10000 pulses: total_steps holds at 9999 and over_flag=1; 300 pulses within one second: sec_steps=255.
- 8 slowclk rises from reset with DISP_SECS=2: disp_sel sequence 0,1,2,3,0, changing at ticks 2, 4, 6 and 8; disp_value matches the selected register at each step.
- Assert rst_n low mid-second, with cur_cnt=5 and total_steps=40: all outputs read 0 within the same cycle; the following tick gives sec_steps=0.
